// File: rtl/uart_fifo_bridge.sv
// Byte bridge between the CPU UART handshake ports and a valid/ready byte stream,
// with independent RX/TX FIFOs. Define UART_FIFO_BRIDGE_LOOPBACK_EN to route TX into RX internally.
module uart_fifo_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uartReadReq,
    output logic                  uartReadAck,
    output logic [DATA_WIDTH-1:0] uartReadData,
    input  logic                  uartWriteReq,
    input  logic [DATA_WIDTH-1:0] uartWriteData,
    output logic                  uartWriteReady,
    input  logic                  hostRxValid,
    input  logic [DATA_WIDTH-1:0] hostRxData,
    output logic                  hostRxReady,
    output logic                  hostTxValid,
    output logic [DATA_WIDTH-1:0] hostTxData,
    input  logic                  hostTxReady,
    output logic [CW-1:0]         rxCount,
    output logic [CW-1:0]         txCount
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACK} rd_state_e;

    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
    logic [AW-1:0]         rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    rd_state_e             state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic [DATA_WIDTH-1:0] rx_wdata;

    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);

    assign tx_push        = uartWriteReq && !tx_full;
    assign uartWriteReady = !tx_full;
    assign hostTxData     = tx_mem_q[tx_rp_q];

`ifdef UART_FIFO_BRIDGE_LOOPBACK_EN
    logic lb_move;
    logic unused_host;
    assign lb_move     = !tx_empty && !rx_full;
    assign rx_push     = lb_move;
    assign rx_wdata    = tx_mem_q[tx_rp_q];
    assign tx_pop      = lb_move;
    assign hostTxValid = 1'b0;
    assign hostRxReady = 1'b0;
    assign unused_host = ^{hostRxValid, hostRxData, hostTxReady};
`else
    assign rx_push     = hostRxValid && !rx_full;
    assign rx_wdata    = hostRxData;
    assign tx_pop      = hostTxReady && !tx_empty;
    assign hostTxValid = !tx_empty;
    assign hostRxReady = !rx_full;
`endif

    // One pop per request pulse: ACK holds until the CPU drops its request.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        rx_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (uartReadReq && !rx_empty) begin
                    rx_pop  = 1'b1;
                    rdata_d = rx_mem_q[rx_rp_q];
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!uartReadReq) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (reset && rx_push) rx_mem_q[rx_wp_q] <= rx_wdata;
        if (reset && tx_push) tx_mem_q[tx_wp_q] <= uartWriteData;
    end

    assign uartReadAck  = ack_q;
    assign uartReadData = rdata_q;
    assign rxCount      = rx_cnt_q;
    assign txCount      = tx_cnt_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed, table-driven bench for uart_fifo_bridge (DEPTH=16, DATA_WIDTH=8).
module tb_uart_fifo_bridge;
    logic       clk = 1'b0;
    logic       reset, uartReadReq, uartReadAck, uartWriteReq, uartWriteReady;
    logic [7:0] uartReadData, uartWriteData, hostRxData, hostTxData;
    logic       hostRxValid, hostRxReady, hostTxValid, hostTxReady;
    logic [4:0] rxCount, txCount;
    int checks = 0;
    int errors = 0;

    uart_fifo_bridge #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .uartReadReq(uartReadReq), .uartReadAck(uartReadAck), .uartReadData(uartReadData),
        .uartWriteReq(uartWriteReq), .uartWriteData(uartWriteData), .uartWriteReady(uartWriteReady),
        .hostRxValid(hostRxValid), .hostRxData(hostRxData), .hostRxReady(hostRxReady),
        .hostTxValid(hostTxValid), .hostTxData(hostTxData), .hostTxReady(hostTxReady),
        .rxCount(rxCount), .txCount(txCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, rreq, wreq; logic [7:0] wd; logic rxv; logic [7:0] rxd; logic txr;
        logic ack; logic [7:0] rd; logic rxrdy, wrdy, txv; logic [7:0] txd; int rxc, txc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, rreq, wreq, input logic [7:0] wd, input logic rxv,
                       input logic [7:0] rxd, input logic txr, input logic ack,
                       input logic [7:0] rd, input logic rxrdy, wrdy, txv,
                       input logic [7:0] txd, input int rxc, txc);
        vec_t v;
        v = '{rst, rreq, wreq, wd, rxv, rxd, txr, ack, rd, rxrdy, wrdy, txv, txd, rxc, txc};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, rreq, wreq, input logic [7:0] wd, input logic rxv,
                         input logic [7:0] rxd, input logic txr);
        reset = rst; uartReadReq = rreq; uartWriteReq = wreq; uartWriteData = wd;
        hostRxValid = rxv; hostRxData = rxd; hostTxReady = txr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] e;
        drive(0, 0, 0, 8'h00, 0, 8'h00, 0);

`ifndef UART_FIFO_BRIDGE_LOOPBACK_EN
        //   rst rq wq wd     rxv rxd   txr | ack rd    rxr wr txv txd   rxc txc
        add(0, 0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 1, 8'hA5, 0,   0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
        add(1, 0, 0, 8'h00, 1, 8'h3C, 0,   0, 8'h00, 1, 1, 0, 8'h00, 2, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 1, 1, 0, 8'h00, 1, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h3C, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 1, 8'h5A, 0,   0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 0, 8'h00, 0,   1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 1, 8'h11, 0, 8'h00, 0,   0, 8'h00, 1, 1, 1, 8'h11, 0, 1);
        add(1, 0, 1, 8'h22, 0, 8'h00, 0,   0, 8'h00, 1, 1, 1, 8'h11, 0, 2);
        add(1, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 1, 1, 1, 8'h22, 0, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 1, 8'h33, 0, 8'h00, 1,   0, 8'h00, 1, 1, 1, 8'h33, 0, 1);
        add(1, 0, 1, 8'h44, 0, 8'h00, 1,   0, 8'h00, 1, 1, 1, 8'h44, 0, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 1, 8'h77, 0,   0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 0, 8'h00, 0,   1, 8'h77, 1, 1, 0, 8'h00, 0, 0);
        add(1, 1, 1, 8'h99, 1, 8'h88, 0,   1, 8'h77, 1, 1, 1, 8'h99, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 1, 8'hAB, 0,   0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 0, 8'h00, 0,   1, 8'hAB, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.rreq, v.wreq, v.wd, v.rxv, v.rxd, v.txr);
            chk($sformatf("v%0d ack", i), uartReadAck, v.ack);
            if (v.ack || !v.rst) chk($sformatf("v%0d rdata", i), uartReadData, v.rd);
            chk($sformatf("v%0d rxReady", i), hostRxReady, v.rxrdy);
            chk($sformatf("v%0d wReady", i), uartWriteReady, v.wrdy);
            chk($sformatf("v%0d txValid", i), hostTxValid, v.txv);
            if (v.txv) chk($sformatf("v%0d txData", i), hostTxData, v.txd);
            chk($sformatf("v%0d rxCount", i), rxCount, v.rxc);
            chk($sformatf("v%0d txCount", i), txCount, v.txc);
        end

        // RX full: 16 pushes, 17th ignored, one read re-raises ready
        drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'h00, 1, 8'(i), 0);
        chk("full count", rxCount, 16);
        chk("full ready", hostRxReady, 0);
        drive(1, 0, 0, 8'h00, 1, 8'hEE, 0);
        chk("full 17th ignored", rxCount, 16);
        drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
        chk("full rd ack", uartReadAck, 1);
        chk("full rd data", uartReadData, 8'h00);
        chk("full rd count", rxCount, 15);
        chk("full rd ready", hostRxReady, 1);
        drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 1, 8'h10, 0);
        chk("refill count", rxCount, 16);
        // pop and push at the same edge on a full FIFO: pop only
        drive(1, 1, 0, 8'h00, 1, 8'hEE, 0);
        chk("fullsim data", uartReadData, 8'h01);
        chk("fullsim count", rxCount, 15);
        drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 2; i < 12; i++) begin
            drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
            chk($sformatf("drain %0d", i), uartReadData, 8'(i));
            drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
        end
        chk("drain count", rxCount, 5);
        q = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        // count 5, push+pop together; read pointer wraps from 15 to 0
        for (int i = 0; i < 8; i++) begin
            q.push_back(8'h20 + 8'(i));
            e = q.pop_front();
            drive(1, 1, 0, 8'h00, 1, 8'h20 + 8'(i), 0);
            chk($sformatf("sim%0d ack", i), uartReadAck, 1);
            chk($sformatf("sim%0d data", i), uartReadData, e);
            chk($sformatf("sim%0d count", i), rxCount, 5);
            drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
        end
`else
        drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("lb rxReady", hostRxReady, 0);
        drive(1, 0, 1, 8'h7E, 0, 8'h00, 1);
        chk("lb txc after write", txCount, 1);
        chk("lb txValid w", hostTxValid, 0);
        drive(1, 0, 0, 8'h00, 1, 8'h55, 1);
        chk("lb moved txc", txCount, 0);
        chk("lb moved rxc", rxCount, 1);
        chk("lb txValid m", hostTxValid, 0);
        drive(1, 1, 0, 8'h00, 1, 8'h55, 1);
        chk("lb ack", uartReadAck, 1);
        chk("lb data", uartReadData, 8'h7E);
        chk("lb host push ignored", rxCount, 0);
        drive(1, 0, 0, 8'h00, 0, 8'h00, 1);
        chk("lb ack drop", uartReadAck, 0);
        chk("lb txValid end", hostTxValid, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
